qs_srt_mstack: RTL and testbench

- Multi-channel successor to the single sort stack: M independent LIFO stacks, each depth N, packed into one single-port SRAM (spsram) of M*N words.
- Used by the quicksort engine to hold partition bounds for several concurrent sort contexts.
- Adds per-channel clear, a global clear, per-channel occupancy, channel-tagged pop data, and out-of-range channel detection.
- One command per cycle; all state is registered.

---
 rtl/qs_srt_mstack_pkg.sv | 19 +
 rtl/qs_srt_mstack_if.sv | 37 +++
 rtl/spsram.sv | 24 ++
 rtl/qs_srt_mstack.sv | 126 ++++++++++++
 tb/tb_qs_srt_mstack.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/qs_srt_mstack_pkg.sv
// Shared types and helpers for the multi-channel sort stack.
package qs_pkg;

  typedef enum logic [1:0] {
    PUSH    = 2'b00,
    POP     = 2'b01,
    CLR     = 2'b10,
    CLR_ALL = 2'b11
  } qs_stk_op_t;

  function automatic int qs_stk_addr(
    input int ch,
    input int idx,
    input int n
  );
    return ch * n + idx;
  endfunction

endpackage

// File: rtl/qs_srt_mstack_if.sv
// Command/response bundle between a sort context and the stack block.
interface qs_srt_mstack_if #(
  parameter int M = 4,
  parameter int N = 16,
  parameter int W = 32
);
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int K  = $clog2(N + 1);

  logic          cmd_vld_r;
  logic [1:0]    cmd_op_r;
  logic [CW-1:0] cmd_ch_r;
  logic [W-1:0]  cmd_push_dat_r;
  logic          cmd_err_w;
  logic [W-1:0]  head_r;
  logic [CW-1:0] head_ch_r;
  logic          head_vld_r;
  logic [M-1:0]  empty_r;
  logic [M-1:0]  full_r;
  logic [M*K-1:0] occ_r;

  modport master (
    output cmd_vld_r, cmd_op_r,
    output cmd_ch_r, cmd_push_dat_r,
    input  cmd_err_w, head_r,
    input  head_ch_r, head_vld_r,
    input  empty_r, full_r, occ_r
  );

  modport slave (
    input  cmd_vld_r, cmd_op_r,
    input  cmd_ch_r, cmd_push_dat_r,
    output cmd_err_w, head_r,
    output head_ch_r, head_vld_r,
    output empty_r, full_r, occ_r
  );
endinterface

// File: rtl/spsram.sv
// Single-port synchronous SRAM, one-cycle read latency.
module spsram #(
  parameter int W = 32,
  parameter int D = 64,
  localparam int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/qs_srt_mstack.sv
// M independent LIFO stacks of depth N sharing one SRAM.
// Pops return channel-tagged data two cycles after issue.
module qs_srt_mstack
  import qs_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 16,
  parameter int W = 32
) (
  input logic            clk,
  input logic            rst,
  qs_srt_mstack_if.slave bus
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int K  = $clog2(N + 1);
  localparam int AW = $clog2(M * N);
  localparam logic [31:0] MU = 32'(M);

  qs_stk_op_t    op;
  logic          is_push, is_pop;
  logic          is_clr, is_clra;
  logic          ch_ok, err;
  logic [CW-1:0] chi;
  logic [K-1:0]  cur, idx;
  logic          do_push, do_pop;
  logic          do_clr, do_clra;
  logic [AW-1:0] addr;
  logic [W-1:0]  rd_dat;
  logic          s1_vld;
  logic [CW-1:0] s1_ch;
  logic [K-1:0]  cnt [M];
  logic          emp [M];
  logic          ful [M];

  assign op = qs_stk_op_t'(bus.cmd_op_r);

  always_comb begin
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_clr  = 1'b0;
    is_clra = 1'b0;
    unique case (op)
      PUSH:    is_push = 1'b1;
      POP:     is_pop  = 1'b1;
      CLR:     is_clr  = 1'b1;
      CLR_ALL: is_clra = 1'b1;
    endcase
  end

  assign ch_ok = 32'(bus.cmd_ch_r) < MU;
  // Out-of-range channels are steered to 0 so array reads stay legal.
  assign chi = ch_ok ? bus.cmd_ch_r : '0;
  assign cur = cnt[chi];

  assign err = bus.cmd_vld_r & ~is_clra &
               (~ch_ok |
                (is_push & (cur == K'(N))) |
                (is_pop & (cur == '0)));
  assign bus.cmd_err_w = err;

  assign do_push = bus.cmd_vld_r & ~err & is_push;
  assign do_pop  = bus.cmd_vld_r & ~err & is_pop;
  assign do_clr  = bus.cmd_vld_r & ~err & is_clr;
  assign do_clra = bus.cmd_vld_r & is_clra;

  assign idx  = is_push ? cur : cur - K'(1);
  assign addr = AW'(qs_stk_addr(int'(chi),
                                int'(idx), N));

  spsram #(
    .W(W),
    .D(M * N)
  ) u_mem (
    .clk  (clk),
    .ce   (do_push | do_pop),
    .we   (do_push),
    .addr (addr),
    .din  (bus.cmd_push_dat_r),
    .dout (rd_dat)
  );

  for (genvar c = 0; c < M; c++) begin : g_ch
    logic sel;
    assign sel = (chi == CW'(c));

    always_ff @(posedge clk) begin
      if (rst || do_clra || (do_clr && sel)) begin
        cnt[c] <= '0;
        emp[c] <= 1'b1;
        ful[c] <= 1'b0;
      end else if (do_push && sel) begin
        cnt[c] <= cnt[c] + K'(1);
        emp[c] <= 1'b0;
        ful[c] <= (cnt[c] == K'(N - 1));
      end else if (do_pop && sel) begin
        cnt[c] <= cnt[c] - K'(1);
        emp[c] <= (cnt[c] == K'(1));
        ful[c] <= 1'b0;
      end
    end

    assign bus.occ_r[c*K +: K] = cnt[c];
    assign bus.empty_r[c]      = emp[c];
    assign bus.full_r[c]       = ful[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld         <= 1'b0;
      bus.head_vld_r <= 1'b0;
    end else begin
      s1_vld         <= do_pop;
      bus.head_vld_r <= s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    s1_ch <= chi;
    if (s1_vld && !rst) begin
      bus.head_r    <= rd_dat;
      bus.head_ch_r <= s1_ch;
    end
  end

endmodule

// File: tb/tb_qs_srt_mstack.sv
// Directed checks for qs_srt_mstack with M=4, N=4, W=32.
module tb_qs_srt_mstack;
  import qs_pkg::*;

  localparam int M = 4;
  localparam int N = 4;
  localparam int W = 32;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  qs_srt_mstack_if #(.M(M), .N(N), .W(W)) bus ();

  qs_srt_mstack #(.M(M), .N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(
    input logic       vld,
    input qs_stk_op_t op,
    input logic [1:0] ch,
    input logic [31:0] dat
  );
    bus.cmd_vld_r      = vld;
    bus.cmd_op_r       = op;
    bus.cmd_ch_r       = ch;
    bus.cmd_push_dat_r = dat;
    #1;
  endtask

  task automatic idle();
    cmd(1'b0, PUSH, 2'd0, 32'hDEAD_BEEF);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [K-1:0] occ(input int c);
    return bus.occ_r[c*K +: K];
  endfunction

  initial begin
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_empty", 64'(bus.empty_r), 64'hF);
    chk("rst_full", 64'(bus.full_r), 64'h0);
    chk("rst_occ", 64'(bus.occ_r), 64'h0);
    chk("rst_hvld", 64'(bus.head_vld_r), 64'h0);

    for (int i = 0; i < 4; i++) begin
      cmd(1'b1, PUSH, 2'd2, 32'hA0 + 32'(i));
      chk("push2_err", 64'(bus.cmd_err_w), 64'h0);
      tick();
    end
    chk("ch2_occ4", 64'(occ(2)), 64'd4);
    chk("ch2_full", 64'(bus.full_r), 64'h4);
    chk("ch2_empty", 64'(bus.empty_r), 64'hB);

    cmd(1'b1, POP, 2'd2, 32'h0);
    tick();
    chk("pop_lat1", 64'(bus.head_vld_r), 64'h0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cmd(1'b1, POP, 2'd2, 32'h0);
      else idle();
      tick();
      chk("pop_vld", 64'(bus.head_vld_r), 64'h1);
      chk("pop_dat", 64'(bus.head_r), 64'hA3 - 64'(i));
      chk("pop_ch", 64'(bus.head_ch_r), 64'd2);
    end
    chk("ch2_occ0", 64'(occ(2)), 64'd0);
    chk("ch2_empty1", 64'(bus.empty_r), 64'hF);
    tick();
    chk("hvld_drop", 64'(bus.head_vld_r), 64'h0);
    chk("head_hold", 64'(bus.head_r), 64'hA0);

    for (int i = 0; i < 4; i++) begin
      cmd(1'b1, PUSH, 2'd1, 32'hB0 + 32'(i));
      tick();
    end
    cmd(1'b1, PUSH, 2'd1, 32'hB4);
    chk("full_err", 64'(bus.cmd_err_w), 64'h1);
    tick();
    chk("full_occ", 64'(occ(1)), 64'd4);
    cmd(1'b1, POP, 2'd1, 32'h0);
    chk("pop1_err", 64'(bus.cmd_err_w), 64'h0);
    tick();
    idle();
    tick();
    chk("nowrite", 64'(bus.head_r), 64'hB3);
    chk("nowrite_ch", 64'(bus.head_ch_r), 64'd1);
    cmd(1'b1, CLR, 2'd1, 32'h0);
    chk("clr_err", 64'(bus.cmd_err_w), 64'h0);
    tick();
    chk("clr_occ", 64'(bus.occ_r), 64'h0);
    chk("clr_empty", 64'(bus.empty_r), 64'hF);

    cmd(1'b1, POP, 2'd0, 32'h0);
    chk("empty_err", 64'(bus.cmd_err_w), 64'h1);
    tick();
    idle();
    tick();
    chk("empty_hvld", 64'(bus.head_vld_r), 64'h0);
    chk("empty_occ", 64'(bus.occ_r), 64'h0);

    cmd(1'b1, PUSH, 2'd0, 32'h11);
    tick();
    cmd(1'b1, PUSH, 2'd3, 32'h22);
    tick();
    chk("mix_occ", 64'(bus.occ_r), 64'h201);
    cmd(1'b1, POP, 2'd0, 32'h0);
    tick();
    cmd(1'b1, POP, 2'd3, 32'h0);
    tick();
    chk("mix0_dat", 64'(bus.head_r), 64'h11);
    chk("mix0_ch", 64'(bus.head_ch_r), 64'd0);
    idle();
    tick();
    chk("mix3_vld", 64'(bus.head_vld_r), 64'h1);
    chk("mix3_dat", 64'(bus.head_r), 64'h22);
    chk("mix3_ch", 64'(bus.head_ch_r), 64'd3);

    for (int i = 0; i < 3; i++) begin
      cmd(1'b1, PUSH, 2'd2, 32'hC0 + 32'(i));
      tick();
    end
    cmd(1'b1, PUSH, 2'd1, 32'hD0);
    tick();
    chk("pre_occ", 64'(bus.occ_r), 64'h0C8);
    cmd(1'b1, POP, 2'd2, 32'h0);
    tick();
    cmd(1'b1, CLR_ALL, 2'd0, 32'h0);
    chk("clra_err", 64'(bus.cmd_err_w), 64'h0);
    tick();
    chk("clra_vld", 64'(bus.head_vld_r), 64'h1);
    chk("clra_dat", 64'(bus.head_r), 64'hC2);
    chk("clra_ch", 64'(bus.head_ch_r), 64'd2);
    chk("clra_occ", 64'(bus.occ_r), 64'h0);
    chk("clra_empty", 64'(bus.empty_r), 64'hF);

    cmd(1'b1, PUSH, 2'd3, 32'hE0);
    tick();
    cmd(1'b1, POP, 2'd3, 32'h0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    chk("rstmid_vld", 64'(bus.head_vld_r), 64'h0);
    chk("rstmid_emp", 64'(bus.empty_r), 64'hF);
    rst = 1'b0;
    tick();
    chk("rstpost_vld", 64'(bus.head_vld_r), 64'h0);
    cmd(1'b1, POP, 2'd3, 32'h0);
    chk("rstpop_err", 64'(bus.cmd_err_w), 64'h1);
    tick();
    idle();
    tick();
    chk("rstpop_vld", 64'(bus.head_vld_r), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
